// File: rtl/udp_photo_tx_if.sv
// Frame-buffer read port and eth_rmii UDP payload port used by udp_photo_tx.
// The master side is the photo transmitter. The slave side is the
// environment, which is the DDR3 frame buffer plus the eth_rmii core.
`timescale 1ns/1ps
interface udp_photo_tx_if;
  logic        ddr3_rd_vs;
  logic        ddr3_rd_ready;
  logic        ddr3_rd_en;
  logic [15:0] ddr3_rd_data;
  logic        udp_txstart;
  logic [15:0] udp_txamount;
  logic        udp_txreq;
  logic        udp_txbusy;
  logic [7:0]  udp_txdata;

  modport master (
    output ddr3_rd_vs, ddr3_rd_en, udp_txstart, udp_txamount, udp_txdata,
    input  ddr3_rd_ready, ddr3_rd_data, udp_txreq, udp_txbusy
  );

  modport slave (
    input  ddr3_rd_vs, ddr3_rd_en, udp_txstart, udp_txamount, udp_txdata,
    output ddr3_rd_ready, ddr3_rd_data, udp_txreq, udp_txbusy
  );
endinterface

// File: rtl/udp_photo_tx.sv
// Photo frame transmitter. It sends a 12-byte header packet first, then
// PKT_NUM-1 data packets of PKT_SIZE 16-bit words each, read from the frame
// buffer. The words go to eth_rmii one byte per request, high byte first.
`timescale 1ns/1ps
module udp_photo_tx #(
  parameter int unsigned  PKT_NUM    = 361,
  parameter int unsigned  PKT_SIZE   = 480,
  parameter logic [15:0]  IMG_W      = 16'h01E0,
  parameter logic [15:0]  IMG_H      = 16'h0168,
  parameter int unsigned  GAP_CYCLES = 64
) (
  input  logic             rmii_clk,
  input  logic             rst_n,
  input  logic             frame_start,
  output logic             busy,
  output logic             frame_done,
  udp_photo_tx_if.master   bus
);

  localparam int unsigned BYTES_DATA = 2 * PKT_SIZE;
  localparam int unsigned BYTE_MAX   = (BYTES_DATA > 12) ? BYTES_DATA : 12;
  localparam int unsigned BC_W       = $clog2(BYTE_MAX);
  localparam int unsigned PKT_W      = (PKT_NUM > 1) ? $clog2(PKT_NUM) : 1;
  localparam int unsigned GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [31:0]       IMG_SIZE    = 32'(IMG_W) * 32'(IMG_H) * 32'd2;
  localparam logic [15:0]       HDR_AMOUNT  = 16'd12;
  localparam logic [15:0]       DATA_AMOUNT = 16'(BYTES_DATA);
  localparam logic [BC_W-1:0]   HDR_LAST    = BC_W'(11);
  localparam logic [BC_W-1:0]   DATA_LAST   = BC_W'(BYTES_DATA - 1);
  localparam logic [PKT_W-1:0]  PKT_LAST    = PKT_W'(PKT_NUM - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD    = GAP_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PKT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0]       cur_word_q, cur_word_d;
  logic              fetch_q, fetch_d;     // first word of a data packet requested
  logic              rd_lat_q, rd_lat_d;   // read data arrives on the bus this cycle
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              rd_vs_q, rd_vs_d;
  logic              rd_en_q, rd_en_d;
  logic              txstart_q, txstart_d;
  logic [15:0]       txamount_q, txamount_d;
  logic [7:0]        txdata_q, txdata_d;

  // Fixed header: "BM", width, height, byte size of the image, channel count.
  function automatic logic [7:0] header_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h42;
      4'd1:    b = 8'h4D;
      4'd2:    b = IMG_W[15:8];
      4'd3:    b = IMG_W[7:0];
      4'd4:    b = IMG_H[15:8];
      4'd5:    b = IMG_H[7:0];
      4'd6:    b = IMG_SIZE[31:24];
      4'd7:    b = IMG_SIZE[23:16];
      4'd8:    b = IMG_SIZE[15:8];
      4'd9:    b = IMG_SIZE[7:0];
      4'd10:   b = 8'h00;
      4'd11:   b = 8'h02;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign bus.ddr3_rd_vs   = rd_vs_q;
  assign bus.ddr3_rd_en   = rd_en_q;
  assign bus.udp_txstart  = txstart_q;
  assign bus.udp_txamount = txamount_q;
  assign bus.udp_txdata   = txdata_q;

  // State and output registers; reset drops everything back to idle at once.
  always_ff @(posedge rmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pkt_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      cur_word_q   <= 16'h0000;
      fetch_q      <= 1'b0;
      rd_lat_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_vs_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      txstart_q    <= 1'b0;
      txamount_q   <= 16'h0000;
      txdata_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      pkt_cnt_q    <= pkt_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cur_word_q   <= cur_word_d;
      fetch_q      <= fetch_d;
      rd_lat_q     <= rd_lat_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rd_vs_q      <= rd_vs_d;
      rd_en_q      <= rd_en_d;
      txstart_q    <= txstart_d;
      txamount_q   <= txamount_d;
      txdata_q     <= txdata_d;
    end
  end

  // Next-state logic: packet sequencing, byte selection and read prefetch.
  always_comb begin
    state_d      = state_q;
    pkt_cnt_d    = pkt_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    fetch_d      = fetch_q;
    busy_d       = busy_q;
    txamount_d   = txamount_q;
    txdata_d     = txdata_q;
    frame_done_d = 1'b0;
    rd_vs_d      = 1'b0;
    rd_en_d      = 1'b0;
    txstart_d    = 1'b0;
    // A read strobed last cycle has its word on the bus now.
    rd_lat_d     = rd_en_q;
    if (rd_lat_q) begin
      cur_word_d = bus.ddr3_rd_data;
    end else begin
      cur_word_d = cur_word_q;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          pkt_cnt_d  = '0;
          byte_cnt_d = '0;
          fetch_d    = 1'b0;
          rd_vs_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_START;
        end else begin
          state_d    = S_IDLE;
        end
      end

      S_START: begin
        if (pkt_cnt_q == '0) begin
          if (!bus.udp_txbusy) begin
            txamount_d = HDR_AMOUNT;
            txstart_d  = 1'b1;
            state_d    = S_SEND;
          end else begin
            state_d    = S_START;
          end
        end else if (fetch_q) begin
          // Wait for the first word of the packet before starting it.
          if (rd_lat_q) begin
            txamount_d = DATA_AMOUNT;
            txstart_d  = 1'b1;
            fetch_d    = 1'b0;
            state_d    = S_SEND;
          end else begin
            state_d    = S_START;
          end
        end else if (bus.ddr3_rd_ready && !bus.udp_txbusy) begin
          rd_en_d = 1'b1;
          fetch_d = 1'b1;
        end else begin
          state_d = S_START;
        end
      end

      S_SEND: begin
        if (bus.udp_txreq) begin
          if (pkt_cnt_q == '0) begin
            txdata_d = header_byte(4'(byte_cnt_q));
          end else if (byte_cnt_q[0]) begin
            txdata_d = cur_word_q[7:0];
            // Prefetch the next word unless this was the packet's last one.
            if (byte_cnt_q != DATA_LAST) begin
              rd_en_d = 1'b1;
            end else begin
              rd_en_d = 1'b0;
            end
          end else begin
            txdata_d = cur_word_q[15:8];
          end
          if (((pkt_cnt_q == '0) && (byte_cnt_q == HDR_LAST)) ||
              ((pkt_cnt_q != '0) && (byte_cnt_q == DATA_LAST))) begin
            state_d = S_WAIT;
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
          end
        end else begin
          state_d = S_SEND;
        end
      end

      S_WAIT: begin
        // Extra requests here leave txdata holding the last byte.
        if (!bus.udp_txbusy) begin
          gap_cnt_d = GAP_LOAD;
          state_d   = S_GAP;
        end else begin
          state_d   = S_WAIT;
        end
      end

      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          if (pkt_cnt_q == PKT_LAST) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            pkt_cnt_d    = '0;
            byte_cnt_d   = '0;
            state_d      = S_IDLE;
          end else begin
            pkt_cnt_d    = pkt_cnt_q + PKT_W'(1);
            byte_cnt_d   = '0;
            state_d      = S_START;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_udp_photo_tx.sv
// Scoreboard bench for udp_photo_tx: it drives random frame-buffer contents,
// models eth_rmii, and compares the byte stream and control pulses.
`timescale 1ns/1ps
module tb_udp_photo_tx;
  localparam int PKT_NUM    = 5;
  localparam int PKT_SIZE   = 8;
  localparam int GAP_CYCLES = 8;
  localparam int WORDS      = (PKT_NUM - 1) * PKT_SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic busy, frame_done;

  udp_photo_tx_if ifc();

  udp_photo_tx #(
    .PKT_NUM(PKT_NUM), .PKT_SIZE(PKT_SIZE), .IMG_W(16'h01E0), .IMG_H(16'h0168),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .rmii_clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .busy(busy), .frame_done(frame_done), .bus(ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, ts_cnt = 0, vs_cnt = 0, fd_cnt = 0, rd_cnt = 0;
  int busy_fall_cyc = -1000;
  int extra_pkt = -1, hold_pkt = -1;
  bit extra_pend = 1'b0;
  int ts_base, vs_base, fd_base, rd_base;
  logic [7:0]  last_byte = 8'h00;
  logic [15:0] mem [WORDS];
  logic [7:0]  hdr [12] = '{8'h42, 8'h4D, 8'h01, 8'hE0, 8'h01, 8'h68,
                            8'h00, 8'h05, 8'h46, 8'h00, 8'h00, 8'h02};
  logic [7:0]  exp_q [$];
  logic [15:0] amt_q [$];

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Frame buffer: vs rewinds, each strobe returns the next word one clock later.
  initial begin
    int ptr;
    ptr = 0;
    ifc.ddr3_rd_data <= 16'h0000;
    forever begin
      @(posedge clk);
      if (ifc.ddr3_rd_vs) begin
        ptr = 0;
      end else if (ifc.ddr3_rd_en) begin
        ifc.ddr3_rd_data <= (ptr < WORDS) ? mem[ptr] : 16'hDEAD;
        ptr++;
        rd_cnt++;
      end
    end
  end

  // Pulse counters and packet-start monitor.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
        if (ifc.ddr3_rd_vs) vs_cnt++;
        if (frame_done) fd_cnt++;
        if (ifc.udp_txstart) begin
          ts_cnt++;
          chk("txstart_while_txbusy", ifc.udp_txbusy, 0);
          chk("txstart_expected", amt_q.size() > 0, 1);
          if (amt_q.size() > 0) chk("txamount", ifc.udp_txamount, amt_q.pop_front());
          if (ifc.udp_txamount != 16'd12) chk("gap_after_busy_fall", (cyc - busy_fall_cyc) > GAP_CYCLES, 1);
        end
      end
    end
  end

  // Byte monitor: data is checked the clock after each request.
  initial begin
    forever begin
      @(posedge clk);
      if (ifc.udp_txreq && rst_n) begin
        @(negedge clk);
        if (rst_n) begin
          if (extra_pend) begin
            chk("repeat_last_byte", ifc.udp_txdata, last_byte);
            extra_pend = 1'b0;
          end else begin
            chk("byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              last_byte = exp_q.pop_front();
              chk("txdata", ifc.udp_txdata, last_byte);
            end
          end
        end
      end
    end
  end

  task automatic eth_step(input logic [15:0] amt, inout bit aborted, inout bit amt_bad);
    @(negedge clk);
    if (!rst_n) aborted = 1'b1;
    else if (ifc.udp_txamount != amt) amt_bad = 1'b1;
  endtask

  // eth_rmii model: busy for the packet, requests spaced 3..5 clocks.
  initial begin
    int pkt_idx;
    int tail;
    logic [15:0] amt;
    bit aborted, amt_bad;
    pkt_idx = 0;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.udp_txstart) begin
        amt = ifc.udp_txamount;
        pkt_idx = (amt == 16'd12) ? 0 : pkt_idx + 1;
        ifc.udp_txbusy = 1'b1;
        aborted = 1'b0;
        amt_bad = 1'b0;
        for (int i = 0; i < int'(amt) && !aborted; i++) begin
          repeat ($urandom_range(2, 4)) eth_step(amt, aborted, amt_bad);
          if (!aborted) begin
            ifc.udp_txreq = 1'b1;
            eth_step(amt, aborted, amt_bad);
            ifc.udp_txreq = 1'b0;
          end
        end
        if (!aborted && pkt_idx == extra_pkt) begin
          repeat (3) eth_step(amt, aborted, amt_bad);
          if (!aborted) begin
            extra_pend = 1'b1;
            ifc.udp_txreq = 1'b1;
            eth_step(amt, aborted, amt_bad);
            ifc.udp_txreq = 1'b0;
          end
        end
        tail = (pkt_idx == hold_pkt) ? 200 : int'($urandom_range(1, 4));
        repeat (tail) if (!aborted) eth_step(amt, aborted, amt_bad);
        ifc.udp_txreq = 1'b0;
        ifc.udp_txbusy = 1'b0;
        if (!aborted) begin
          busy_fall_cyc = cyc;
          chk("txamount_stable", amt_bad, 0);
        end
      end
    end
  end

  task automatic start_frame();
    for (int w = 0; w < WORDS; w++) mem[w] = 16'($urandom);
    for (int i = 0; i < 12; i++) exp_q.push_back(hdr[i]);
    for (int w = 0; w < WORDS; w++) begin
      exp_q.push_back(mem[w][15:8]);
      exp_q.push_back(mem[w][7:0]);
    end
    amt_q.push_back(16'd12);
    for (int p = 1; p < PKT_NUM; p++) amt_q.push_back(16'(2 * PKT_SIZE));
    ts_base = ts_cnt; vs_base = vs_cnt; fd_base = fd_cnt; rd_base = rd_cnt;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_frame();
    int t;
    t = 0;
    while (fd_cnt == fd_base && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done_seen", fd_cnt != fd_base, 1);
    repeat (20) @(negedge clk);
    chk("frame_done_once", fd_cnt - fd_base, 1);
    chk("rd_vs_once", vs_cnt - vs_base, 1);
    chk("txstart_count", ts_cnt - ts_base, PKT_NUM);
    chk("read_count", rd_cnt - rd_base, WORDS);
    chk("bytes_left", exp_q.size(), 0);
    chk("amounts_left", amt_q.size(), 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic wait_ts(input int target);
    int t;
    t = 0;
    while (ts_cnt < target && t < 10000) begin
      @(negedge clk);
      t++;
    end
    chk("txstart_reached", ts_cnt >= target, 1);
  endtask

  task automatic wait_txbusy_low();
    int t;
    t = 0;
    while (ifc.udp_txbusy && t < 10000) begin
      @(negedge clk);
      t++;
    end
    chk("txbusy_fell", ifc.udp_txbusy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_rd_vs"}, ifc.ddr3_rd_vs, 0);
    chk({tag, "_rd_en"}, ifc.ddr3_rd_en, 0);
    chk({tag, "_txstart"}, ifc.udp_txstart, 0);
    chk({tag, "_txamount"}, ifc.udp_txamount, 0);
    chk({tag, "_txdata"}, ifc.udp_txdata, 0);
  endtask

  initial begin
    int rs, ts, vs;
    ifc.ddr3_rd_ready = 1'b1;
    ifc.udp_txreq = 1'b0;
    ifc.udp_txbusy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Frame A: a second frame_start is ignored, an extra request repeats the last byte, and packet 1 holds busy long.
    extra_pkt = 2; hold_pkt = 1;
    start_frame();
    wait_ts(ts_base + 2);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    chk("busy_ignored_start", busy, 1);
    finish_frame();
    extra_pkt = -1; hold_pkt = -1;

    // Frame B: the frame buffer is not ready before packet 3.
    start_frame();
    wait_ts(ts_base + 3);
    ifc.ddr3_rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    wait_txbusy_low();
    repeat (GAP_CYCLES + 10) @(negedge clk);
    rs = rd_cnt; ts = ts_cnt;
    repeat (500) @(negedge clk);
    chk("stall_no_read", rd_cnt - rs, 0);
    chk("stall_no_txstart", ts_cnt - ts, 0);
    chk("stall_busy", busy, 1);
    ifc.ddr3_rd_ready = 1'b1;
    finish_frame();

    // Frame C: reset arrives during packet 2 and the frame is abandoned.
    start_frame();
    wait_ts(ts_base + 3);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    amt_q.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    rs = rd_cnt; ts = ts_cnt; vs = vs_cnt;
    repeat (60) @(negedge clk);
    chk("post_reset_no_read", rd_cnt - rs, 0);
    chk("post_reset_no_txstart", ts_cnt - ts, 0);
    chk("post_reset_no_vs", vs_cnt - vs, 0);
    chk("post_reset_busy", busy, 0);

    // Frame D: a normal frame after reset.
    start_frame();
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
